// File: rtl/lsu_mem_port_pkg.sv
// Shared constants, state/size encodings and decode helpers for the LSU memory port.
package lsu_mem_port_pkg;

  localparam int WORD_LEN = 32;

  // RISC-V load/store width codes (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DATA,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  // Anything that is not a known byte/half code is handled as a full word.
  function automatic lsu_size_e access_size(input logic [2:0] funct3, input logic we);
    lsu_size_e sz;
    sz = SZ_WORD;
    if (we) begin
      if (funct3 == F3_SB)      sz = SZ_BYTE;
      else if (funct3 == F3_SH) sz = SZ_HALF;
    end else begin
      if (funct3 == F3_LB || funct3 == F3_LBU)      sz = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (sz)
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Byte/half lane extraction with sign/zero extension for loads, and lane merge
// of right-aligned store data into a read word for sub-word stores.
module lsu_lane_align
  import lsu_mem_port_pkg::*;
(
  input  lsu_size_e           size_i,
  input  logic                unsigned_i,
  input  logic [1:0]          off_i,
  input  logic [WORD_LEN-1:0] rdata_i,
  input  logic [WORD_LEN-1:0] wdata_i,
  output logic [WORD_LEN-1:0] load_o,
  output logic [WORD_LEN-1:0] merge_o
);

  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [WORD_LEN-1:0] lane_mask;
  logic [WORD_LEN-1:0] wdata_rep;

  // Select the addressed lane, extend it, and build the merged store word.
  always_comb begin
    byte_sel  = rdata_i[{off_i, 3'b000} +: 8];
    half_sel  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o    = rdata_i;
    lane_mask = '1;
    wdata_rep = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o    = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
        lane_mask = 32'h0000_00FF << {off_i, 3'b000};
        wdata_rep = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        load_o    = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
        lane_mask = off_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata_rep = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
    merge_o = (rdata_i & ~lane_mask) | (wdata_rep & lane_mask);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port between a RISC-V core and a word-wide
// synchronous memory. Sub-word stores are done as read-modify-write.
//
// state    | meaning
// IDLE     | ready for a request
// READ     | word address on mem_addr, memory read in flight
// DATA     | mem_rdata valid: extract load lane or write merged word
// WRITE    | full-word store strobe
// RESP     | response held until resp_ready
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_funct3,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_we,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  lsu_state_e          state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                we_q, we_d;
  logic [1:0]          off_q, off_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [WORD_LEN-1:0] resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_LEN-1:0] mem_wdata_q;

  logic [WORD_LEN-1:0] req_addr_word;
  lsu_size_e           req_size;
  logic                req_mis;
  lsu_size_e           cur_size;
  logic [WORD_LEN-1:0] load_word;
  logic [WORD_LEN-1:0] merge_word;

  if (ADDR_W >= WORD_LEN) begin : g_addr_trunc
    assign req_addr_word = {req_addr[WORD_LEN-1:2], 2'b00};
  end else begin : g_addr_ext
    assign req_addr_word = {{(WORD_LEN-ADDR_W){1'b0}}, req_addr[ADDR_W-1:2], 2'b00};
  end

  assign req_size = access_size(req_funct3, req_we);
  assign req_mis  = is_misaligned(req_size, req_addr[1:0]);
  assign cur_size = access_size(funct3_q, we_q);

  lsu_lane_align u_lane_align (
    .size_i     (cur_size),
    .unsigned_i (funct3_q[2]),
    .off_i      (off_q),
    .rdata_i    (mem_rdata),
    .wdata_i    (wdata_q),
    .load_o     (load_word),
    .merge_o    (merge_word)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;

  // Next state, request capture, response data and memory strobes.
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_we       = 1'b0;
    mem_wdata    = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          funct3_d     = req_funct3;
          we_d         = req_we;
          off_d        = req_addr[1:0];
          wdata_d      = req_wdata;
          resp_rdata_d = '0;
          resp_err_d   = req_mis;
          if (req_mis) begin
            state_d = ST_RESP;
          end else begin
            mem_addr_d = req_addr_word;
            state_d    = (req_we && req_size == SZ_WORD) ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_READ: state_d = ST_DATA;
      ST_DATA: begin
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = merge_word;
        end else begin
          resp_rdata_d = load_word;
        end
        state_d = ST_RESP;
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; mem_wdata_q keeps the last driven write word.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q     <= '0;
      we_q         <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      funct3_q     <= funct3_d;
      we_q         <= we_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small registered word memory model.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];
  logic        mem_init;
  int          we_count = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // memory: write on mem_we, read data registered one cycle after mem_addr
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h0102_0304;
      mem[4] <= 32'h8899_AABB;
      mem[5] <= 32'h1122_3344;
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[5:2]];
    if (mem_we) we_count <= we_count + 1;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic [2:0] f3, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_wes, input int stall);
    int          k;
    int          base;
    logic [31:0] exp_maddr;
    exp_maddr = addr & 32'hFFFF_FFFC;
    @(negedge clk);
    chk_val({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    base       = we_count;
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b0;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      k++;
      if (k == 1 && !exp_err) chk_val({tag, ".mem_addr"}, mem_addr, exp_maddr);
    end while (!resp_valid && k < 12);
    chk_val({tag, ".latency"}, 32'(k), 32'(exp_lat));
    chk_val({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk_val({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk_val({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
      chk_val({tag, ".stall_rdata"}, resp_rdata, exp_rdata);
      chk_val({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk_val({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
    chk_val({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    chk_val({tag, ".we_pulses"}, 32'(we_count - base), 32'(exp_wes));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst        = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = 3'b000;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk_val("rst.resp_err", 32'(resp_err), 32'd0);
    chk_val("rst.resp_rdata", resp_rdata, 32'h0);
    chk_val("rst.mem_we", 32'(mem_we), 32'd0);
    chk_val("rst.mem_addr", mem_addr, 32'h0);
    chk_val("rst.mem_wdata", mem_wdata, 32'h0);
    rst      = 1'b0;
    mem_init = 1'b0;
    chk_val("rst.req_ready", 32'(req_ready), 32'd1);

    //        tag        f3      we    addr          wdata          lat rdata          err  we  stall
    run_req("lb_13",   3'b000, 1'b0, 32'h13, 32'h0,          3, 32'hFFFF_FF88, 1'b0, 0, 0);
    run_req("lbu_13",  3'b100, 1'b0, 32'h13, 32'h0,          3, 32'h0000_0088, 1'b0, 0, 0);
    run_req("lh_12",   3'b001, 1'b0, 32'h12, 32'h0,          3, 32'hFFFF_8899, 1'b0, 0, 0);
    run_req("lhu_10",  3'b101, 1'b0, 32'h10, 32'h0,          3, 32'h0000_AABB, 1'b0, 0, 0);
    run_req("lw_10",   3'b010, 1'b0, 32'h10, 32'h0,          3, 32'h8899_AABB, 1'b0, 0, 0);
    run_req("sb_11",   3'b000, 1'b1, 32'h11, 32'h1234_565A, 3, 32'h0,         1'b0, 1, 0);
    chk_val("sb_11.mem", mem[4], 32'h8899_5ABB);
    run_req("sw_06",   3'b010, 1'b1, 32'h06, 32'hFFFF_FFFF, 1, 32'h0,         1'b1, 0, 0);
    chk_val("sw_06.mem", mem[1], 32'h0102_0304);
    run_req("sw_04",   3'b010, 1'b1, 32'h04, 32'hDEAD_BEEF, 2, 32'h0,         1'b0, 1, 0);
    chk_val("sw_04.mem", mem[1], 32'hDEAD_BEEF);
    run_req("sh_12",   3'b001, 1'b1, 32'h12, 32'h0000_CAFE, 3, 32'h0,         1'b0, 1, 0);
    chk_val("sh_12.mem", mem[4], 32'hCAFE_5ABB);
    run_req("lh_11",   3'b001, 1'b0, 32'h11, 32'h0,          1, 32'h0,         1'b1, 0, 0);
    run_req("lx3_10",  3'b011, 1'b0, 32'h10, 32'h0,          3, 32'hCAFE_5ABB, 1'b0, 0, 0);
    run_req("lx3_12",  3'b011, 1'b0, 32'h12, 32'h0,          1, 32'h0,         1'b1, 0, 0);
    run_req("lw_stall",3'b010, 1'b0, 32'h10, 32'h0,          3, 32'hCAFE_5ABB, 1'b0, 0, 3);

    // reset during DATA of an SH: the strobe already issued completes, nothing follows
    @(negedge clk);
    base       = we_count;
    req_valid  = 1'b1;
    req_funct3 = 3'b001;
    req_we     = 1'b1;
    req_addr   = 32'h14;
    req_wdata  = 32'h0000_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk_val("rst_sh.strobe", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_val("rst_sh.mem_we", 32'(mem_we), 32'd0);
    chk_val("rst_sh.resp_valid", 32'(resp_valid), 32'd0);
    chk_val("rst_sh.mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    chk_val("rst_sh.req_ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk_val("rst_sh.no_resp", 32'(resp_valid), 32'd0);
      chk_val("rst_sh.no_we", 32'(mem_we), 32'd0);
    end
    chk_val("rst_sh.we_pulses", 32'(we_count - base), 32'd1);
    chk_val("rst_sh.mem", mem[5], 32'h1122_BEEF);
    run_req("lw_14",   3'b010, 1'b0, 32'h14, 32'h0,          3, 32'h1122_BEEF, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the byte-address width seen by the core.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_funct3  input  3  RISC-V load/store width code (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port req_wdata  input  `WORD_LEN  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  core consumes the response.
REQ-012 SHALL have port resp_rdata  output  `WORD_LEN  extended load data; 0 for stores.
REQ-013 SHALL have port resp_err  output  1  misaligned access.
REQ-014 SHALL have port mem_addr  output  `WORD_LEN  byte address to the word memory data port.
REQ-015 SHALL have port mem_we  output  1  one-cycle word write strobe.
REQ-016 SHALL have port mem_wdata  output  `WORD_LEN  full word to write.
REQ-017 SHALL have port mem_rdata  input  `WORD_LEN  memory read data, registered one cycle after mem_addr.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, DATA, WRITE and RESP.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted at the edge where req_valid and req_ready are both 1, and it latches funct3, we, addr and wdata.
REQ-020 SHALL, on an accepted load or a sub-word store (SB, SH), transition IDLE->READ->DATA->RESP.
REQ-021 SHALL, on an accepted SW, transition IDLE->WRITE->RESP with no read.
REQ-022 SHALL drive mem_addr = {latched addr[31:2], 2'b00} in READ, DATA and WRITE, and hold the last value otherwise.
REQ-023 SHALL, in DATA for a load, select the byte or half using addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU, and register the result into resp_rdata.
REQ-024 SHALL, in DATA for SB/SH, merge the shifted wdata into mem_rdata only in the addressed lanes, drive mem_wdata with the merged word, and assert mem_we for exactly that cycle.
REQ-025 SHALL, in WRITE, drive mem_wdata = wdata and assert mem_we for exactly one cycle.
REQ-026 SHALL detect misalignment at accept (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0), go IDLE->RESP with resp_err=1, and perform no memory access.
REQ-027 SHALL hold resp_valid=1 in RESP with resp_rdata and resp_err stable until resp_ready=1, then return to IDLE on that edge.
REQ-028 SHALL give this latency from the accept edge T to resp_valid: load T+3; SB/SH T+3; SW T+2; misaligned T+1.
REQ-029 SHALL allow at most one outstanding request; a new accept is possible at the earliest in the cycle after the response handshake.
REQ-030 SHALL treat an unused funct3 code as a word access.
REQ-031 SHALL keep mem_we=0 in every state not named in REQ-024 or REQ-025.

Reset
REQ-032 SHALL, while rst=1 at an edge, set state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-033 SHALL let rst asserted mid-operation abort the operation with no response; a write strobe already issued in the current cycle completes, and none follows.
REQ-034 SHALL assert req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-035 SHALL place WORD_LEN and the funct3 width codes (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010) in the shared consts.vh.
REQ-036 SHALL implement the lane extract/merge logic as the combinational sub-module lsu_lane_align, instantiated once.

Verification
REQ-037 SHALL cover: memory word 0x10 = 0x8899AABB; LB @0x13 -> resp_rdata 0xFFFFFF88 at T+3; LBU @0x13 -> 0x00000088.
REQ-038 SHALL cover: LH @0x12 -> 0xFFFF8899; LHU @0x10 -> 0x0000AABB; LW @0x10 -> 0x8899AABB.
REQ-039 SHALL cover: SB @0x11 with wdata 0x1234565A -> word 0x10 becomes 0x88995ABB, with exactly one mem_we pulse.
REQ-040 SHALL cover: SW @0x06 -> resp_err=1 at T+1, no mem_we, memory unchanged.
REQ-041 SHALL cover: LW with resp_ready held 0 for 3 cycles -> resp_valid and data stable, req_ready=0 throughout, IDLE after the handshake.
REQ-042 SHALL cover: rst pulsed during DATA of an SH -> no response, mem_we=0 after the reset edge, req_ready=1 the next cycle.
